// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back sequencer:
// request kinds, write-register mux selects and sequencer states.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR1  = 2'd1,
    ST_WR2  = 2'd2
  } state_t;

  localparam logic [2:0] K_RD   = 3'd0;
  localparam logic [2:0] K_RT   = 3'd1;
  localparam logic [2:0] K_LINK = 3'd2;
  localparam logic [2:0] K_SP   = 3'd3;
  localparam logic [2:0] K_POP  = 3'd4;

  localparam logic [1:0] SEL_RD = 2'b00;
  localparam logic [1:0] SEL_RT = 2'b01;
  localparam logic [1:0] SEL_RA = 2'b10;
  localparam logic [1:0] SEL_SP = 2'b11;

  function automatic logic kind_legal(input logic [2:0] kind);
    return (kind <= K_POP);
  endfunction

  // POP writes rt first, so it shares the RT select for its first write.
  function automatic logic [1:0] kind_to_sel(input logic [2:0] kind);
    logic [1:0] sel;
    case (kind)
      K_RD:    sel = SEL_RD;
      K_RT:    sel = SEL_RT;
      K_LINK:  sel = SEL_RA;
      K_SP:    sel = SEL_SP;
      K_POP:   sel = SEL_RT;
      default: sel = SEL_RD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wb_write_sequencer.sv
// Write-back sequencer for the single register-file write port: one request per
// instruction, POP split into two writes, honours a stall hold.
module wb_write_sequencer
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [DATA_W-1:0] req_data_a,
  input  logic [DATA_W-1:0] req_data_b,
  input  logic              wb_hold,
  output logic [1:0]        write_reg_sel,
  output logic [DATA_W-1:0] wb_data,
  output logic              reg_write,
  output logic              busy,
  output logic              kind_err,
  output logic [CNT_W-1:0]  wr_count
);

  state_t              state_r, state_s;
  logic [1:0]          sel_r, sel_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic [DATA_W-1:0]   data_b_r, data_b_s;
  logic                pop_r, pop_s;
  logic                kind_err_r, kind_err_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                write_s;
  logic                ready_s;
  logic                accept_s;

  // Write strobe, request handshake and next-state/next-register selection.
  always_comb begin
    write_s    = (state_r != ST_IDLE) && !wb_hold;
    ready_s    = (state_r == ST_IDLE) ||
                 ((state_r == ST_WR1) && write_s && !pop_r) ||
                 ((state_r == ST_WR2) && write_s);
    accept_s   = req_valid && ready_s;
    state_s    = state_r;
    sel_s      = sel_r;
    data_s     = data_r;
    data_b_s   = data_b_r;
    pop_s      = pop_r;
    kind_err_s = 1'b0;

    case (state_r)
      ST_IDLE: state_s = ST_IDLE;
      ST_WR1: begin
        if (write_s && pop_r) begin
          state_s = ST_WR2;
          sel_s   = SEL_SP;
          data_s  = data_b_r;
        end else if (write_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR1;
        end
      end
      ST_WR2: begin
        if (write_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR2;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    // A new request can only be accepted when the current write is the last one,
    // so it safely overrides the completion transition above.
    if (accept_s && kind_legal(req_kind)) begin
      state_s  = ST_WR1;
      sel_s    = kind_to_sel(req_kind);
      data_s   = req_data_a;
      data_b_s = req_data_b;
      pop_s    = (req_kind == K_POP);
    end else if (accept_s) begin
      kind_err_s = 1'b1;
    end else begin
      kind_err_s = 1'b0;
    end
  end

  // Sequencer state, presented write, and completed-write counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      sel_r      <= SEL_RD;
      data_r     <= {DATA_W{1'b0}};
      data_b_r   <= {DATA_W{1'b0}};
      pop_r      <= 1'b0;
      kind_err_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      data_r     <= data_s;
      data_b_r   <= data_b_s;
      pop_r      <= pop_s;
      kind_err_r <= kind_err_s;
      cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, write_s};
    end
  end

  assign req_ready     = ready_s;
  assign reg_write     = write_s;
  assign busy          = (state_r != ST_IDLE);
  assign write_reg_sel = sel_r;
  assign wb_data       = data_r;
  assign kind_err      = kind_err_r;
  assign wr_count      = cnt_r;

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed bench for wb_write_sequencer: a vector table for the main flows plus
// hand-written sequences for reset-in-WR2 and counter wrap.
module tb_wb_write_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_kind;
  logic [31:0] req_data_a, req_data_b;
  logic        wb_hold;
  logic        req_ready, reg_write, busy, kind_err;
  logic [1:0]  write_reg_sel;
  logic [31:0] wb_data;
  logic [15:0] wr_count;

  logic        s_ready, s_reg_write, s_busy, s_kind_err;
  logic [1:0]  s_sel;
  logic [31:0] s_data;
  logic [3:0]  s_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  wb_write_sequencer #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_data_a(req_data_a), .req_data_b(req_data_b),
    .wb_hold(wb_hold), .write_reg_sel(write_reg_sel), .wb_data(wb_data),
    .reg_write(reg_write), .busy(busy), .kind_err(kind_err), .wr_count(wr_count)
  );

  // Narrow-counter instance so the wrap can be reached in a few cycles.
  wb_write_sequencer #(.DATA_W(32), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_ready),
    .req_kind(req_kind), .req_data_a(req_data_a), .req_data_b(req_data_b),
    .wb_hold(wb_hold), .write_reg_sel(s_sel), .wb_data(s_data),
    .reg_write(s_reg_write), .busy(s_busy), .kind_err(s_kind_err), .wr_count(s_count)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
    logic        hold;
    logic        ready;
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        busy;
    logic        kerr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] k, input logic [31:0] a,
                       input logic [31:0] b, input logic h);
    @(posedge clk);
    #1;
    req_valid = v; req_kind = k; req_data_a = a; req_data_b = b; wb_hold = h;
  endtask

  initial begin
    // Each row: inputs applied this cycle, outputs expected in the same cycle.
    vecs[0]  = '{1'b1, 3'd1, 32'h1234,   32'h0,    1'b0, 1'b1, 1'b0, 2'b00, 32'h0,      1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 3'd0, 32'h0,      32'h0,    1'b0, 1'b1, 1'b1, 2'b01, 32'h1234,   1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 3'd4, 32'hAAAA,   32'h7FFC, 1'b0, 1'b1, 1'b0, 2'b01, 32'h1234,   1'b0, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 3'd0, 32'h5555,   32'h0,    1'b0, 1'b0, 1'b1, 2'b01, 32'hAAAA,   1'b1, 1'b0, 16'd1};
    vecs[4]  = '{1'b0, 3'd0, 32'h0,      32'h0,    1'b0, 1'b1, 1'b1, 2'b11, 32'h7FFC,   1'b1, 1'b0, 16'd2};
    vecs[5]  = '{1'b1, 3'd2, 32'h400008, 32'h0,    1'b1, 1'b1, 1'b0, 2'b11, 32'h7FFC,   1'b0, 1'b0, 16'd3};
    vecs[6]  = '{1'b0, 3'd0, 32'h0,      32'h0,    1'b1, 1'b0, 1'b0, 2'b10, 32'h400008, 1'b1, 1'b0, 16'd3};
    vecs[7]  = '{1'b1, 3'd0, 32'h9999,   32'h0,    1'b1, 1'b0, 1'b0, 2'b10, 32'h400008, 1'b1, 1'b0, 16'd3};
    vecs[8]  = '{1'b0, 3'd0, 32'h0,      32'h0,    1'b1, 1'b0, 1'b0, 2'b10, 32'h400008, 1'b1, 1'b0, 16'd3};
    vecs[9]  = '{1'b0, 3'd0, 32'h0,      32'h0,    1'b0, 1'b1, 1'b1, 2'b10, 32'h400008, 1'b1, 1'b0, 16'd3};
    vecs[10] = '{1'b1, 3'd6, 32'hDEAD,   32'h0,    1'b0, 1'b1, 1'b0, 2'b10, 32'h400008, 1'b0, 1'b0, 16'd4};
    vecs[11] = '{1'b1, 3'd0, 32'h11,     32'h0,    1'b0, 1'b1, 1'b0, 2'b10, 32'h400008, 1'b0, 1'b1, 16'd4};
    vecs[12] = '{1'b1, 3'd3, 32'h22,     32'h0,    1'b0, 1'b1, 1'b1, 2'b00, 32'h11,     1'b1, 1'b0, 16'd4};
    vecs[13] = '{1'b1, 3'd0, 32'h33,     32'h0,    1'b0, 1'b1, 1'b1, 2'b11, 32'h22,     1'b1, 1'b0, 16'd5};
    vecs[14] = '{1'b0, 3'd0, 32'h0,      32'h0,    1'b0, 1'b1, 1'b1, 2'b00, 32'h33,     1'b1, 1'b0, 16'd6};
    vecs[15] = '{1'b0, 3'd0, 32'h0,      32'h0,    1'b0, 1'b1, 1'b0, 2'b00, 32'h33,     1'b0, 1'b0, 16'd7};

    reset = 1'b0; req_valid = 1'b0; req_kind = 3'd0;
    req_data_a = 32'h0; req_data_b = 32'h0; wb_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rw",    {31'd0, reg_write}, 32'd0);
    check("reset_busy",  {31'd0, busy},      32'd0);
    check("reset_sel",   {30'd0, write_reg_sel}, 32'd0);
    check("reset_data",  wb_data,            32'd0);
    check("reset_cnt",   {16'd0, wr_count},  32'd0);
    check("reset_kerr",  {31'd0, kind_err},  32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].kind, vecs[i].a, vecs[i].b, vecs[i].hold);
      @(negedge clk);
      check($sformatf("v%0d_ready", i), {31'd0, req_ready},     {31'd0, vecs[i].ready});
      check($sformatf("v%0d_rw", i),    {31'd0, reg_write},     {31'd0, vecs[i].rw});
      check($sformatf("v%0d_sel", i),   {30'd0, write_reg_sel}, {30'd0, vecs[i].sel});
      check($sformatf("v%0d_data", i),  wb_data,                vecs[i].data);
      check($sformatf("v%0d_busy", i),  {31'd0, busy},          {31'd0, vecs[i].busy});
      check($sformatf("v%0d_kerr", i),  {31'd0, kind_err},      {31'd0, vecs[i].kerr});
      check($sformatf("v%0d_cnt", i),   {16'd0, wr_count},      {16'd0, vecs[i].cnt});
    end

    // Reset asserted while the second POP write is pending.
    drive(1'b1, 3'd4, 32'hA1, 32'hB2, 1'b0);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("pop_wr1_sel", {30'd0, write_reg_sel}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("pop_wr2_sel",  {30'd0, write_reg_sel}, 32'd3);
    check("pop_wr2_data", wb_data, 32'hB2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_wr2_busy", {31'd0, busy},      32'd0);
    check("rst_wr2_rw",   {31'd0, reg_write}, 32'd0);
    check("rst_wr2_cnt",  {16'd0, wr_count},  32'd0);
    check("rst_wr2_sel",  {30'd0, write_reg_sel}, 32'd0);
    @(negedge clk);
    check("rst_wr2_rw2",  {31'd0, reg_write}, 32'd0);

    // Fifteen back-to-back RD writes, then one more to wrap the 4-bit counter.
    for (int i = 0; i < 15; i++) drive(1'b1, 3'd0, i, 32'h0, 1'b0);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("burst_cnt",       {16'd0, wr_count}, 32'd15);
    check("small_cnt_full",  {28'd0, s_count},  32'd15);
    drive(1'b1, 3'd0, 32'h77, 32'h0, 1'b0);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("last_rw", {31'd0, reg_write}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("wrap_main_cnt",  {16'd0, wr_count}, 32'd16);
    check("wrap_small_cnt", {28'd0, s_count},  32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
